// File: rtl/sirv_gnrl_rrwr_arb.sv
// ---------------------------------------------------------------------------
// sirv_gnrl_rrwr_arb
//
// Round-robin write arbiter in front of one shared DW-bit register that
// resets (and flushes) to all ones. Each cycle at most one valid requester
// is granted, its data is captured, and the writer's index is reported.
//
// Optional feature macro: SIRV_RRWR_ARB_LOCK_EN
//   When defined, a requester that writes with req_lock=1 keeps the grant
//   for a back-to-back burst until it writes with req_lock=0. When not
//   defined, req_lock is ignored and locked is tied low.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   req_valid  [N]     per-requester write request
//   req_data   [N*DW]  write data, requester i at [i*DW +: DW]
//   req_lock   [N]     keep the grant after this write (lock build only)
//   req_ready  [N]     one-hot-or-zero grant, combinational from req_valid
//   flush      clear the shared register to all ones, release the lock
//   qout       [DW]    shared register value
//   qout_vld   one-cycle pulse in the cycle after a write
//   gnt_id     [IW]    index of the last writer
//   locked     lock currently held
// ---------------------------------------------------------------------------
module sirv_gnrl_rrwr_arb #(
    parameter int  N  = 4,
    parameter int  DW = 32,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    input  logic [N-1:0]    req_lock,
    output logic [N-1:0]    req_ready,
    input  logic            flush,
    output logic [DW-1:0]   qout,
    output logic            qout_vld,
    output logic [IW-1:0]   gnt_id,
    output logic            locked
);

    localparam int SW = IW + 1;

    logic [DW-1:0] qout_p1;
    logic          vld_p1;
    logic [IW-1:0] gnt_id_p1;
    logic [IW-1:0] ptr_p1;

    logic          rr_found;
    logic [IW-1:0] rr_id;
    logic          win_found;
    logic [IW-1:0] win_id;
    logic          hs;
    logic          ptr_adv;

    // Increment modulo N so non-power-of-two N never points past N-1.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (i == IW'(N - 1))
            return '0;
        else
            return i + IW'(1);
    endfunction

    // Stage p0: round-robin scan starting at ptr, wrapping modulo N.
    // ptr < N and k < N, so one conditional subtraction wraps the sum.
    always_comb begin
        logic [SW-1:0] sum;
        logic [IW-1:0] idx;
        rr_found = 1'b0;
        rr_id    = '0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_p1} + SW'(k);
            if (sum >= SW'(N))
                sum = sum - SW'(N);
            idx = sum[IW-1:0];
            if (!rr_found && req_valid[idx]) begin
                rr_found = 1'b1;
                rr_id    = idx;
            end
        end
    end

`ifdef SIRV_RRWR_ARB_LOCK_EN
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_st_e;

    lock_st_e      state_p1, state_d;
    logic [IW-1:0] owner_p1, owner_d;

    // While locked only the owner is a candidate; others simply wait.
    always_comb begin
        win_found = rr_found;
        win_id    = rr_id;
        if (state_p1 == ST_LOCKED) begin
            win_found = req_valid[owner_p1];
            win_id    = owner_p1;
        end
    end

    // Lock FSM: ptr stays put while a burst is in progress; the releasing
    // write advances it past the owner like any ordinary write.
    always_comb begin
        state_d = state_p1;
        owner_d = owner_p1;
        ptr_adv = hs;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (hs) begin
            case (state_p1)
                ST_IDLE: begin
                    if (req_lock[win_id]) begin
                        state_d = ST_LOCKED;
                        owner_d = win_id;
                        ptr_adv = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (req_lock[win_id])
                        ptr_adv = 1'b0;
                    else
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= ST_IDLE;
            owner_p1 <= '0;
        end else begin
            state_p1 <= state_d;
            owner_p1 <= owner_d;
        end
    end

    assign locked = (state_p1 == ST_LOCKED);
`else
    logic unused_lock;

    assign win_found   = rr_found;
    assign win_id      = rr_id;
    assign ptr_adv     = hs;
    assign locked      = 1'b0;
    assign unused_lock = ^req_lock;
`endif

    // Flush and reset both block the grant for the cycle they are asserted.
    assign hs = win_found & ~flush & ~rst;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++)
            req_ready[i] = hs && (win_id == IW'(i));
    end

    // Stage p1: shared register, writer index and write pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            qout_p1   <= '1;
            vld_p1    <= 1'b0;
            gnt_id_p1 <= '0;
            ptr_p1    <= '0;
        end else if (flush) begin
            qout_p1 <= '1;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= hs;
            if (hs) begin
                qout_p1   <= req_data[int'(win_id)*DW +: DW];
                gnt_id_p1 <= win_id;
                if (ptr_adv)
                    ptr_p1 <= next_idx(win_id);
            end
        end
    end

    assign qout     = qout_p1;
    assign qout_vld = vld_p1;
    assign gnt_id   = gnt_id_p1;

endmodule

// File: tb/tb_sirv_gnrl_rrwr_arb.sv
// ---------------------------------------------------------------------------
// Self-checking bench for sirv_gnrl_rrwr_arb (N=4, DW=32).
// Expected writes are pushed to a scoreboard queue when a grant is predicted
// and popped when the DUT pulses qout_vld. Lock scenarios run when
// SIRV_RRWR_ARB_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_sirv_gnrl_rrwr_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_lock;
    logic [N-1:0]    req_ready;
    logic            flush;
    logic [DW-1:0]   qout;
    logic            qout_vld;
    logic [IW-1:0]   gnt_id;
    logic            locked;

    sirv_gnrl_rrwr_arb #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .flush     (flush),
        .qout      (qout),
        .qout_vld  (qout_vld),
        .gnt_id    (gnt_id),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            id;
    } exp_t;

    exp_t          sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] dat[N];
    logic [N-1:0]  pend;

    // reference model state
    int            m_ptr    = 0;
    int            m_gnt    = 0;
    logic [DW-1:0] m_qout   = '1;
    bit            m_locked = 1'b0;
    int            m_owner  = 0;

    // Requester protocol monitor: a waiting request may not be withdrawn.
    logic [N-1:0] pend_a = '0;
    always @(posedge clk) begin
        if (!rst) begin
            assert ((req_valid & pend_a) == pend_a)
                else $error("request withdrawn before grant");
            pend_a <= req_valid & ~req_ready;
        end else begin
            pend_a <= '0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] lk);
        req_valid = v;
        req_lock  = lk;
        for (int i = 0; i < N; i++)
            req_data[i*DW +: DW] = dat[i];
    endtask

    // One clock: predict grant, check ready, advance model, check outputs.
    task automatic cycle();
        logic [N-1:0] er;
        bit           hs;
        int           id;
        bit           lk;
        exp_t         e;
        #1;
        hs = 1'b0;
        id = 0;
        if (!rst && !flush) begin
            if (m_locked) begin
                if (req_valid[m_owner]) begin
                    hs = 1'b1;
                    id = m_owner;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (!hs && req_valid[i]) begin
                        hs = 1'b1;
                        id = i;
                    end
                end
            end
        end
        er = hs ? (N'(1) << id) : '0;
        chk("req_ready", 64'(req_ready), 64'(er));
        lk = hs ? req_lock[id] : 1'b0;
        if (hs) begin
            e.d  = req_data[id*DW +: DW];
            e.id = id;
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            m_qout = '1; m_ptr = 0; m_gnt = 0; m_locked = 1'b0; m_owner = 0;
        end else if (flush) begin
            m_qout = '1; m_locked = 1'b0;
        end else if (hs) begin
            m_qout = req_data[id*DW +: DW];
            m_gnt  = id;
`ifdef SIRV_RRWR_ARB_LOCK_EN
            if (!m_locked && lk) begin
                m_locked = 1'b1;
                m_owner  = id;
            end else if (!(m_locked && lk)) begin
                m_locked = 1'b0;
                m_ptr    = (id + 1) % N;
            end
`else
            m_ptr = (id + 1) % N;
`endif
        end
        pend = rst ? '0 : (req_valid & ~er);
        #1;
        if (qout_vld === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_vld", 64'(qout_vld), 64'(0));
            end else begin
                e = sb_q.pop_front();
                chk("sb_qout", 64'(qout), 64'(e.d));
                chk("sb_gnt_id", 64'(gnt_id), 64'(e.id));
            end
        end
        chk("sb_missed_write", 64'(sb_q.size()), 64'(0));
        chk("qout", 64'(qout), 64'(m_qout));
        chk("gnt_id", 64'(gnt_id), 64'(m_gnt));
        chk("locked", 64'(locked), 64'(m_locked));
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        pend = '0;
        for (int i = 0; i < N; i++) dat[i] = 32'h1111_1111 * 32'(i + 1);
        drive('0, '0);

        // reset, with requests present in the second reset cycle
        cycle();
        drive('1, '0);
        cycle();
        chk("rst_qout", 64'(qout), 64'hFFFF_FFFF);
        chk("rst_vld", 64'(qout_vld), 64'(0));
        chk("rst_gnt", 64'(gnt_id), 64'(0));
        rst = 1'b0;
        drive('0, '0);
        cycle();
        chk("idle_vld", 64'(qout_vld), 64'(0));

        // rotation with all requesters valid
        drive('1, '0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rot_gnt", 64'(gnt_id), 64'(k % N));
            chk("rot_qout", 64'(qout), 64'(32'h1111_1111 * 32'((k % N) + 1)));
            chk("rot_vld", 64'(qout_vld), 64'(1));
        end
        rst = 1'b1;
        drive('0, '0);
        cycle();
        rst = 1'b0;

        // pointer wrap with a gap
        drive(4'b1000, '0); cycle();
        chk("wrap_gnt3", 64'(gnt_id), 64'(3));
        drive(4'b0110, '0); cycle();
        chk("wrap_gnt1", 64'(gnt_id), 64'(1));
        drive(4'b0100, '0); cycle();
        chk("wrap_gnt2", 64'(gnt_id), 64'(2));
        chk("wrap_qout2", 64'(qout), 64'h3333_3333);
        drive('0, '0); cycle();

        // flush collides with a request
        flush = 1'b1;
        drive(4'b0100, '0); cycle();
        chk("flush_qout", 64'(qout), 64'hFFFF_FFFF);
        chk("flush_vld", 64'(qout_vld), 64'(0));
        chk("flush_gnt_kept", 64'(gnt_id), 64'(2));
        flush = 1'b0;
        cycle();
        chk("post_flush_gnt", 64'(gnt_id), 64'(2));
        chk("post_flush_vld", 64'(qout_vld), 64'(1));
        drive('0, '0); cycle();

        // random traffic, occasional flush, random lock bits
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i]) dat[i] = $urandom;
            flush = ($urandom_range(0, 9) == 0);
            drive(pend | N'($urandom), N'($urandom));
            cycle();
        end
        flush = 1'b0;
        rst = 1'b1;
        drive('0, '0);
        cycle();
        rst = 1'b0;

`ifdef SIRV_RRWR_ARB_LOCK_EN
        // move ptr to 2, then 2 locks while 0 and 1 wait
        for (int i = 0; i < N; i++) dat[i] = 32'hA000_0000 + 32'(i);
        drive(4'b0010, '0); cycle();
        drive(4'b0111, 4'b0100); cycle();
        chk("lk_on", 64'(locked), 64'(1));
        chk("lk_gnt", 64'(gnt_id), 64'(2));
        for (int k = 0; k < 3; k++) begin
            dat[2] = 32'hB000_0000 + 32'(k);
            drive(4'b0111, 4'b0100); cycle();
            chk("lk_burst_gnt", 64'(gnt_id), 64'(2));
            chk("lk_burst_qout", 64'(qout), 64'(32'hB000_0000 + 32'(k)));
        end
        drive(4'b0011, 4'b0100); cycle();
        chk("lk_hold_noval", 64'(qout_vld), 64'(0));
        chk("lk_hold", 64'(locked), 64'(1));
        drive(4'b0111, 4'b0000); cycle();
        chk("lk_release", 64'(locked), 64'(0));
        drive(4'b0011, '0); cycle();
        chk("lk_next_gnt0", 64'(gnt_id), 64'(0));
        drive(4'b0010, '0); cycle();
        chk("lk_next_gnt1", 64'(gnt_id), 64'(1));
        // reset while locked
        drive(4'b0100, 4'b0100); cycle();
        chk("lk_on2", 64'(locked), 64'(1));
        rst = 1'b1;
        drive('0, '0); cycle();
        chk("lk_rst_locked", 64'(locked), 64'(0));
        chk("lk_rst_qout", 64'(qout), 64'hFFFF_FFFF);
        rst = 1'b0;
        drive(4'b1001, '0); cycle();
        chk("lk_rst_ptr0", 64'(gnt_id), 64'(0));
        drive(4'b1000, '0); cycle();
        drive('0, '0); cycle();
`else
        drive(4'b0100, 4'b1111); cycle();
        chk("nolock_locked", 64'(locked), 64'(0));
        drive(4'b1010, 4'b1111); cycle();
        chk("nolock_rot", 64'(gnt_id), 64'(3));
        drive(4'b0010, '0); cycle();
        drive('0, '0); cycle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
